// File: rtl/cornigera_pkg.sv
// Shared core types: data word, register address and the hardwired zero register.
package cornigera_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NUM_ARCH   = 32;
   localparam int unsigned REG_ADDR_W = $clog2(NUM_ARCH);
   localparam int unsigned ZERO_REG   = 0;

   typedef logic [DATA_W-1:0]     DataType;
   typedef logic [REG_ADDR_W-1:0] RegAddrType;

endpackage : cornigera_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for pending writebacks.
//   clk, rst_n        : clock, async active-low reset
//   alloc_en/idx      : mark a register as pending a write
//   write_en/write_to : writeback that clears the pending mark
//   busy              : registered busy vector, bit 0 always 0
module regfile_scoreboard
   import cornigera_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alloc_en,
   input  logic [ADDR_W-1:0]   alloc_idx,
   input  logic                write_en,
   input  logic [ADDR_W-1:0]   write_to,
   output logic [NUM_REGS-1:0] busy
);

   logic [NUM_REGS-1:0] busy_next_c;

   // Clear on writeback first, then set on alloc so a new producer wins a same-index collision.
   always_comb begin
      busy_next_c = busy;
      if (write_en && (write_to != ADDR_W'(ZERO_REG))) begin
         busy_next_c[write_to] = 1'b0;
      end
      if (alloc_en && (alloc_idx != ADDR_W'(ZERO_REG))) begin
         busy_next_c[alloc_idx] = 1'b1;
      end
      busy_next_c[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next_c;
      end
   end

endmodule : regfile_scoreboard

// File: rtl/regfile_multiport.sv
// Multi-read-port register bank with one write port, optional write-first bypass
// and a busy scoreboard for the issue stage. Register 0 reads as zero.
//   clk, rst_n             : clock, async active-low reset
//   write_en/to/data       : single write port
//   read_from / read_data  : per-port address, registered data (1-cycle latency)
//   alloc_en / alloc_idx   : mark register pending a write
//   read_busy              : combinational busy flag per read port
//   any_busy               : OR of all busy bits
module regfile_multiport
   import cornigera_pkg::*;
#(
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned READ_PORTS = 2,
   parameter int unsigned BYPASS     = 1,
   parameter int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             write_en,
   input  logic [ADDR_W-1:0]                write_to,
   input  DataType                          write_data,
   input  logic [READ_PORTS-1:0][ADDR_W-1:0] read_from,
   output DataType [READ_PORTS-1:0]         read_data,
   input  logic                             alloc_en,
   input  logic [ADDR_W-1:0]                alloc_idx,
   output logic [READ_PORTS-1:0]            read_busy,
   output logic                             any_busy
);

   DataType             bank [NUM_REGS];
   DataType             rd_next_c [READ_PORTS];
   logic [NUM_REGS-1:0] busy;
   logic                wr_valid_c;

   assign wr_valid_c = write_en && (write_to != ADDR_W'(ZERO_REG));

   // Bank storage; entry 0 is only ever written by reset and so stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            bank[i] <= '0;
         end
      end else if (wr_valid_c) begin
         bank[write_to] <= write_data;
      end
   end

   // Per-port next read value and busy masking.
   for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      logic addr_zero_c;
      logic hit_c;

      assign addr_zero_c = (read_from[p] == ADDR_W'(ZERO_REG));
      // Write in flight to this port's address, only meaningful when forwarding.
      assign hit_c       = (BYPASS != 0) && wr_valid_c && (write_to == read_from[p]);

      assign rd_next_c[p] = addr_zero_c ? '0 :
                            hit_c       ? write_data :
                                          bank[read_from[p]];

      assign read_busy[p] = busy[read_from[p]] && !hit_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data <= '0;
      end else begin
         for (int p = 0; p < READ_PORTS; p++) begin
            read_data[p] <= rd_next_c[p];
         end
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc_en  (alloc_en),
      .alloc_idx (alloc_idx),
      .write_en  (write_en),
      .write_to  (write_to),
      .busy      (busy)
   );

   assign any_busy = |busy;

endmodule : regfile_multiport

// File: tb/tb_regfile_multiport.sv
// Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus and
// compares both against an array-based reference model.
module tb_regfile_multiport;

   logic              clk;
   logic              rst_n;
   logic              write_en;
   logic [4:0]        write_to;
   logic [31:0]       write_data;
   logic [1:0][4:0]   read_from;
   logic              alloc_en;
   logic [4:0]        alloc_idx;

   logic [1:0][31:0]  rd1, rd0;
   logic [1:0]        rb1, rb0;
   logic              ab1, ab0;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] m_bank [32];
   logic [31:0] m_busy;

   regfile_multiport #(.NUM_REGS(32), .READ_PORTS(2), .BYPASS(1)) u_dut_byp (
      .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_to(write_to),
      .write_data(write_data), .read_from(read_from), .read_data(rd1),
      .alloc_en(alloc_en), .alloc_idx(alloc_idx), .read_busy(rb1), .any_busy(ab1));

   regfile_multiport #(.NUM_REGS(32), .READ_PORTS(2), .BYPASS(0)) u_dut_nobyp (
      .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_to(write_to),
      .write_data(write_data), .read_from(read_from), .read_data(rd0),
      .alloc_en(alloc_en), .alloc_idx(alloc_idx), .read_busy(rb0), .any_busy(ab0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_bank[i] = '0;
      m_busy = '0;
   endtask

   task automatic drive(input logic we, input logic [4:0] wt, input logic [31:0] wd,
                        input logic ae, input logic [4:0] ai,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      write_en = we; write_to = wt; write_data = wd;
      alloc_en = ae; alloc_idx = ai;
      read_from[0] = ra0; read_from[1] = ra1;
   endtask

   // Called at posedge+1 with inputs driven: checks combinational flags,
   // advances one clock, then checks registered read data.
   task automatic cycle();
      logic [31:0] exp_rd1 [2];
      logic [31:0] exp_rd0 [2];
      logic        wr_hit;
      logic [4:0]  a;
      #2;
      for (int p = 0; p < 2; p++) begin
         a = read_from[p];
         wr_hit = write_en && (write_to == a) && (a != 5'd0);
         check($sformatf("busy_byp[%0d]", p), 32'(rb1[p]),
               32'((a != 5'd0) && m_busy[a] && !wr_hit));
         check($sformatf("busy_nobyp[%0d]", p), 32'(rb0[p]),
               32'((a != 5'd0) && m_busy[a]));
         exp_rd0[p] = (a == 5'd0) ? 32'd0 : m_bank[a];
         exp_rd1[p] = (a == 5'd0) ? 32'd0 : (wr_hit ? write_data : m_bank[a]);
      end
      check("any_busy_byp", 32'(ab1), 32'(m_busy != 32'd0));
      check("any_busy_nobyp", 32'(ab0), 32'(m_busy != 32'd0));
      if (write_en && write_to != 5'd0) begin
         m_bank[write_to] = write_data;
         m_busy[write_to] = 1'b0;
      end
      if (alloc_en && alloc_idx != 5'd0) m_busy[alloc_idx] = 1'b1;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         check($sformatf("rd_byp[%0d]", p), rd1[p], exp_rd1[p]);
         check($sformatf("rd_nobyp[%0d]", p), rd0[p], exp_rd0[p]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_byp", rd1[0], 32'd0);
      check("reset_any_busy", 32'(ab1), 32'd0);
      rst_n = 1'b1;

      // Every register reads zero after reset.
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
         cycle();
      end

      // Basic write then read.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0); cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);        cycle();

      // Same-cycle write and read of r7 on both ports.
      drive(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0);       cycle();
      drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);       cycle();
      check("bypass_r7_byp", rd1[0], 32'h22);
      check("bypass_r7_nobyp", rd0[1], 32'h11);

      // Zero register: writes and allocs ignored.
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0); cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);        cycle();

      // Scoreboard sequence on r3.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);        cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);        cycle();
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd0);       cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);        cycle();
      drive(1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 5'd3, 5'd3);       cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);        cycle();
      check("r3_cleared", 32'(ab1), 32'd0);

      // Alloc and write to different indices.
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 5'd12, 5'd9);     cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd9);       cycle();

      // Randomized traffic over a narrow address range to force collisions.
      for (int n = 0; n < 300; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         cycle();
      end

      // Async reset between edges while a write and alloc are driven.
      drive(1'b1, 5'd9, 32'hAA, 1'b1, 5'd4, 5'd9, 5'd4);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rd_byp", rd1[0], 32'd0);
      check("midrst_rd_nobyp", rd0[1], 32'd0);
      check("midrst_any_byp", 32'(ab1), 32'd0);
      check("midrst_any_nobyp", 32'(ab0), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd4);
      rst_n = 1'b1;
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd9);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_regfile_multiport
